// File: rtl/hamming_tx_if.sv
// hamming_tx_if: byte input handshake plus line-side outputs of the Hamming(7,4) transmitter.
// master = byte source / line observer, slave = the transmitter controller.
interface hamming_tx_if;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       tx_bit;
   logic       tx_en;
   logic       frame_start;
   logic       frame_done;
   logic       underrun;
   logic       busy;

   modport master (
      output din, din_valid,
      input  din_ready, tx_bit, tx_en, frame_start, frame_done, underrun, busy
   );

   modport slave (
      input  din, din_valid,
      output din_ready, tx_bit, tx_en, frame_start, frame_done, underrun, busy
   );
endinterface

// File: rtl/hamming_tx_ctrl.sv
// hamming_tx_ctrl: buffers bytes, encodes each into a 16-bit Hamming(7,4) word and serialises frames.
// Define HAMMING_TX_SYNC_EN to prefix every frame with SYNC_WORD.
module hamming_tx_ctrl #(
   parameter int unsigned BIT_DIV   = 4,
   parameter int unsigned FRAME_LEN = 4,
   parameter int unsigned GAP_BITS  = 8,
   parameter logic [15:0] SYNC_WORD = 16'hA5C3
) (
   input  logic        clk,
   input  logic        rst_n,
   hamming_tx_if.slave tx_if
);
   // state | meaning
   // IDLE  | line quiet, waiting for a buffered byte
   // SYNC  | shifting out SYNC_WORD
   // DATA  | shifting out codewords
   // GAP   | forced idle bit periods after a frame
   typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

`ifdef HAMMING_TX_SYNC_EN
   localparam bit SYNC_EN = 1'b1;
`else
   localparam bit SYNC_EN = 1'b0;
`endif

   localparam logic [7:0] DIV_LAST  = 8'(BIT_DIV - 1);
   localparam logic [7:0] GAP_LAST  = 8'(GAP_BITS - 1);
   localparam logic [7:0] FRAME_CNT = 8'(FRAME_LEN);

   state_t      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [7:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  word_cnt_q, word_cnt_d;
   logic [15:0] shift_q, shift_d;
   logic [7:0]  hold_q, hold_d;
   logic        hold_valid_q, hold_valid_d;
   logic        frame_start_q, frame_start_d;
   logic        frame_done_q, frame_done_d;
   logic        underrun_q, underrun_d;
   logic        take, fill, bit_end, word_end, line_active;
   logic [7:0]  wc_inc;

   function automatic logic [6:0] ham74(input logic [3:0] d);
      return {d, d[3] ^ d[2] ^ d[1], d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0]};
   endfunction

   function automatic logic [15:0] encode(input logic [7:0] b);
      return {ham74(b[7:4]), ham74(b[3:0]), 2'b00};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         div_q         <= '0;
         bit_cnt_q     <= '0;
         word_cnt_q    <= '0;
         shift_q       <= '0;
         hold_q        <= '0;
         hold_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         bit_cnt_q     <= bit_cnt_d;
         word_cnt_q    <= word_cnt_d;
         shift_q       <= shift_d;
         hold_q        <= hold_d;
         hold_valid_q  <= hold_valid_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         underrun_q    <= underrun_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      word_cnt_d    = word_cnt_q;
      shift_d       = shift_q;
      take          = 1'b0;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;
      underrun_d    = 1'b0;
      bit_end       = (div_q == DIV_LAST);
      word_end      = bit_end && (bit_cnt_q == 8'd15);
      wc_inc        = word_cnt_q + 8'd1;
      div_d         = (state_q == IDLE || bit_end) ? 8'd0 : div_q + 8'd1;

      case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            if (hold_valid_q) begin
               frame_start_d = 1'b1;
               word_cnt_d    = '0;
               if (SYNC_EN) begin
                  state_d = SYNC;
                  shift_d = SYNC_WORD;
               end else begin
                  state_d = DATA;
                  shift_d = encode(hold_q);
                  take    = 1'b1;
               end
            end
         end
         SYNC: begin
            if (word_end) begin
               bit_cnt_d = '0;
               if (hold_valid_q) begin
                  state_d = DATA;
                  shift_d = encode(hold_q);
                  take    = 1'b1;
               end else begin
                  state_d    = GAP;
                  underrun_d = 1'b1;
               end
            end else if (bit_end) begin
               bit_cnt_d = bit_cnt_q + 8'd1;
               shift_d   = {shift_q[14:0], 1'b0};
            end
         end
         DATA: begin
            if (word_end) begin
               bit_cnt_d  = '0;
               word_cnt_d = wc_inc;
               if (wc_inc == FRAME_CNT) begin
                  state_d      = GAP;
                  frame_done_d = 1'b1;
               end else if (hold_valid_q) begin
                  shift_d = encode(hold_q);
                  take    = 1'b1;
               end else begin
                  state_d    = GAP;
                  underrun_d = 1'b1;
               end
            end else if (bit_end) begin
               bit_cnt_d = bit_cnt_q + 8'd1;
               shift_d   = {shift_q[14:0], 1'b0};
            end
         end
         GAP: begin
            if (bit_end) begin
               if (bit_cnt_q == GAP_LAST) begin
                  state_d   = IDLE;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // a fill can only happen while the register is empty, so it never races a take
      fill         = tx_if.din_valid & ~hold_valid_q;
      hold_valid_d = fill | (hold_valid_q & ~take);
      hold_d       = fill ? tx_if.din : hold_q;
   end

   assign line_active = (state_q == SYNC) || (state_q == DATA);

   always_comb begin
      tx_if.din_ready   = ~hold_valid_q;
      tx_if.tx_en       = line_active;
      tx_if.tx_bit      = line_active & shift_q[15];
      tx_if.busy        = (state_q != IDLE);
      tx_if.frame_start = frame_start_q;
      tx_if.frame_done  = frame_done_q;
      tx_if.underrun    = underrun_q;
   end
endmodule

// File: tb/tb_hamming_tx_ctrl.sv
// Self-checking bench for hamming_tx_ctrl: table vectors, corner sequences and a random stream
// compared against a line decoder and a codeword model.
module tb_hamming_tx_ctrl;
   localparam int BIT_DIV   = 4;
   localparam int FRAME_LEN = 3;
   localparam int GAP_BITS  = 8;
   localparam logic [15:0] SYNC_WORD = 16'hA5C3;
`ifdef HAMMING_TX_SYNC_EN
   localparam int SYNC = 1;
`else
   localparam int SYNC = 0;
`endif
   localparam int WORD_CLK = 16 * BIT_DIV;
   localparam int GAP_CLK  = GAP_BITS * BIT_DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   hamming_tx_if bus ();

   hamming_tx_ctrl #(
      .BIT_DIV  (BIT_DIV),
      .FRAME_LEN(FRAME_LEN),
      .GAP_BITS (GAP_BITS),
      .SYNC_WORD(SYNC_WORD)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .tx_if(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   int en_cnt = 0, last_len = 0, gap_cnt = 0, last_gap = 0, frame_words = 0;
   int n_fs = 0, n_fd = 0, n_ur = 0, fs_cyc = 0, fd_cyc = 0;
   int ph, widx;
   logic cur_bit = 1'b0;
   logic [15:0] sh = '0;

   typedef struct {
      logic [7:0]  din;
      logic [15:0] word;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // parity bits are the XOR over the data-bit subsets {3,2,1}, {3,2,0}, {3,1,0}
   function automatic logic [6:0] ham74(input logic [3:0] d);
      return {d, ^(d & 4'b1110), ^(d & 4'b1101), ^(d & 4'b1011)};
   endfunction

   function automatic logic [15:0] enc(input logic [7:0] b);
      int w;
      w = int'(ham74(b[7:4])) * 512 + int'(ham74(b[3:0])) * 4;
      return 16'(w);
   endfunction

   // line decoder: rebuilds words from tx_bit and checks pulse rules
   always @(negedge clk) begin
      if (!rst_n) begin
         en_cnt  = 0;
         gap_cnt = 0;
      end else begin
         if (bus.frame_start | bus.frame_done | bus.underrun)
            chk("pulse_exclusive", $countones({bus.frame_start, bus.frame_done, bus.underrun}), 1);
         if (bus.frame_start) begin
            n_fs++;
            fs_cyc      = cyc;
            frame_words = 0;
            chk("start_with_tx_en", bus.tx_en, 1);
         end
         if (bus.frame_done) begin
            n_fd++;
            fd_cyc = cyc;
            chk("done_word_count", frame_words, FRAME_LEN);
         end
         if (bus.underrun) begin
            n_ur++;
            chk("underrun_short_frame", frame_words < FRAME_LEN, 1);
         end
         if (bus.tx_en) begin
            ph = en_cnt % BIT_DIV;
            if (ph == 0) cur_bit = bus.tx_bit;
            else chk("bit_hold", bus.tx_bit, cur_bit);
            if (ph == BIT_DIV - 1) begin
               sh = {sh[14:0], cur_bit};
               if ((en_cnt / BIT_DIV) % 16 == 15) begin
                  widx = en_cnt / WORD_CLK;
`ifdef HAMMING_TX_SYNC_EN
                  if (widx == 0) chk("sync_word", sh, SYNC_WORD);
                  else begin
                     got_q.push_back(sh);
                     frame_words++;
                  end
`else
                  got_q.push_back(sh);
                  frame_words++;
`endif
               end
            end
            en_cnt++;
         end else begin
            if (en_cnt != 0) last_len = en_cnt;
            en_cnt = 0;
         end
         if (bus.busy && !bus.tx_en) gap_cnt++;
         else begin
            if (gap_cnt != 0) last_gap = gap_cnt;
            gap_cnt = 0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      bus.din       = b;
      bus.din_valid = 1'b1;
      while (!bus.din_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready_timeout", bus.din_ready, 1);
      @(negedge clk);
      bus.din_valid = 1'b0;
      chk("ready_drop_after_fill", bus.din_ready, 0);
      if (n < 2000) exp_q.push_back(enc(b));
   endtask

   task automatic wait_quiet(input string name);
      int n = 0;
      int q = 0;
      while (q < 3 && n < 5000) begin
         @(negedge clk);
         #1;
         n++;
         if (!bus.busy && bus.din_ready) q++;
         else q = 0;
      end
      chk({name, "_quiet_timeout"}, q >= 3, 1);
   endtask

   task automatic cmp_words(input string name);
      int n;
      chk({name, "_word_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk($sformatf("%s_word%0d", name, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int ur0, fd0, fs0, n;
      logic [7:0] b;
      bus.din       = '0;
      bus.din_valid = 1'b0;
      tbl[0] = '{8'hB4, 16'hB298};
      tbl[1] = '{8'h00, 16'h0000};
      tbl[2] = '{8'hFF, 16'hFFFC};
      tbl[3] = '{8'h0F, 16'h01FC};
      tbl[4] = '{8'hF0, 16'hFE00};
      tbl[5] = '{8'h12, 16'h1654};

      #1 rst_n = 1'b0;
      #11;
      chk("rst_din_ready", bus.din_ready, 1);
      chk("rst_tx_bit", bus.tx_bit, 0);
      chk("rst_tx_en", bus.tx_en, 0);
      chk("rst_frame_start", bus.frame_start, 0);
      chk("rst_frame_done", bus.frame_done, 0);
      chk("rst_underrun", bus.underrun, 0);
      chk("rst_busy", bus.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // single-byte frames: fixed codewords, each ends in underrun because FRAME_LEN is 3
      for (int i = 0; i < 6; i++) begin
         ur0 = n_ur;
         fd0 = n_fd;
         send_byte(tbl[i].din);
         wait_quiet("tbl");
         chk("tbl_word_count", got_q.size(), 1);
         if (got_q.size() > 0) chk($sformatf("tbl_word_%0h", tbl[i].din), got_q[0], tbl[i].word);
         chk("tbl_underrun", n_ur - ur0, 1);
         chk("tbl_no_done", n_fd - fd0, 0);
         chk("tbl_frame_len", last_len, WORD_CLK * (1 + SYNC));
         chk("tbl_gap_len", last_gap, GAP_CLK);
         got_q.delete();
         exp_q.delete();
      end

      // two of three words supplied
      ur0 = n_ur;
      fd0 = n_fd;
      send_byte(8'hB4);
      send_byte(8'h00);
      wait_quiet("under");
      chk("under_pulse", n_ur - ur0, 1);
      chk("under_no_done", n_fd - fd0, 0);
      chk("under_frame_len", last_len, WORD_CLK * (2 + SYNC));
      chk("under_gap_len", last_gap, GAP_CLK);
      cmp_words("under");

      // full frame with backpressure on the third byte
      ur0 = n_ur;
      fd0 = n_fd;
      for (int i = 0; i < FRAME_LEN; i++) send_byte(8'($urandom));
      wait_quiet("full");
      chk("full_done", n_fd - fd0, 1);
      chk("full_no_underrun", n_ur - ur0, 0);
      chk("full_frame_len", last_len, WORD_CLK * (FRAME_LEN + SYNC));
      chk("full_gap_len", last_gap, GAP_CLK);
      cmp_words("full");

      // byte accepted during GAP, next frame starts right after the IDLE cycle
      fd0 = n_fd;
      send_byte(8'h5A);
      send_byte(8'hC3);
      send_byte(8'h81);
      n = 0;
      while (n_fd == fd0 && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("gapacc_done_seen", n_fd - fd0, 1);
      repeat (5) @(negedge clk);
      chk("gapacc_in_gap", {bus.busy, bus.tx_en}, 2'b10);
      chk("gapacc_ready", bus.din_ready, 1);
      fs0 = n_fs;
      send_byte(8'h3C);
      n = 0;
      while (n_fs == fs0 && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("gapacc_start_seen", n_fs - fs0, 1);
      chk("gapacc_spacing", fs_cyc - fd_cyc, GAP_CLK + 1);
      wait_quiet("gapacc");
      cmp_words("gapacc");

      // reset in the middle of bit 5 of the first word on the line
      send_byte(8'hB4);
      n = 0;
      while (en_cnt < 5 * BIT_DIV + 1 && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("rstmid_reached_bit5", en_cnt >= 5 * BIT_DIV + 1, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid_tx_en", bus.tx_en, 0);
      chk("rstmid_tx_bit", bus.tx_bit, 0);
      chk("rstmid_busy", bus.busy, 0);
      chk("rstmid_din_ready", bus.din_ready, 1);
      chk("rstmid_pulses", {bus.frame_start, bus.frame_done, bus.underrun}, 3'b000);
      exp_q.delete();
      got_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rstmid_after_busy", bus.busy, 0);
      chk("rstmid_after_ready", bus.din_ready, 1);

      // random stream with random spacing; every byte must appear once, in order
      ur0 = n_ur;
      fd0 = n_fd;
      fs0 = n_fs;
      for (int i = 0; i < 40; i++) begin
         b = 8'($urandom);
         send_byte(b);
         repeat ($urandom_range(0, 90)) @(negedge clk);
      end
      wait_quiet("rand");
      chk("rand_frame_accounting", (n_fd - fd0) + (n_ur - ur0), n_fs - fs0);
      cmp_words("rand");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
